// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared definitions for the load/store unit
// Contents: access size encodings, FSM state enum, size_bytes() helper.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RMW_WRITE = 2'b01,
        ST_DONE      = 2'b10
    } lsu_state_t;

    // Access size in bytes for a Size encoding.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational lane extract/extend and store merge
// Ports:
//   word       in  64  containing memory word
//   offset     in  3   byte offset of the access (little-endian)
//   Size       in  2   access size encoding
//   SignExt    in  1   1 = sign-extend the loaded lane
//   StoreData  in  64  right-justified store value
//   LoadValue  out 64  extended load lane
//   MergedWord out 64  word with the addressed lane replaced by StoreData
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  offset,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    input  logic [63:0] StoreData,
    output logic [63:0] LoadValue,
    output logic [63:0] MergedWord
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] lane_mask;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        lane_mask = '1;
        LoadValue = shifted;
        case (Size)
            SZ_B: begin
                lane_mask = 64'h0000_0000_0000_00FF;
                LoadValue = {{56{SignExt & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                lane_mask = 64'h0000_0000_0000_FFFF;
                LoadValue = {{48{SignExt & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                lane_mask = 64'h0000_0000_FFFF_FFFF;
                LoadValue = {{32{SignExt & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                // A dword access is always at offset 0, so no extension applies.
                lane_mask = '1;
                LoadValue = shifted;
            end
        endcase
    end

    assign MergedWord = (word & ~(lane_mask << shamt)) | ((StoreData & lane_mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sub-word load/store sequencer for a 64-bit data memory
// Ports:
//   Clock, Reset_n                 clock, synchronous active-low reset
//   Req, MemRead, MemWrite         request strobe and kind (held while Busy)
//   Size, SignExt, Address         access size, load extension, byte address
//   StoreData                      right-justified store value
//   Busy, Done, Fault              stall, completion pulse, illegal-request pulse
//   LoadData                       extended load result, held until next Done
//   DmAddress, DmWriteData         word address and write data to memory
//   DmRead, DmWrite, DmReadData    memory strobes and combinational read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              SignExt,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] StoreData,
    output logic              Busy,
    output logic              Done,
    output logic              Fault,
    output logic [DATA_W-1:0] LoadData,
    output logic [ADDR_W-1:0] DmAddress,
    output logic [DATA_W-1:0] DmWriteData,
    output logic              DmRead,
    output logic              DmWrite,
    input  logic [DATA_W-1:0] DmReadData
);

    lsu_state_t        state;
    logic [DATA_W-1:0] load_data_q;
    logic [DATA_W-1:0] merged_q;
    logic              fault_q;

    logic [2:0]        offset;
    logic [3:0]        nbytes;
    logic              conflict;
    logic              misaligned;
    logic              illegal;
    logic              is_load;
    logic              is_store;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merged;

    logic              rd_raw;
    logic              wr_raw;
    logic [DATA_W-1:0] wdata_raw;

    assign offset     = Address[2:0];
    assign nbytes     = size_bytes(Size);
    assign conflict   = MemRead & MemWrite;
    assign misaligned = |({1'b0, offset} & (nbytes - 4'd1));
    assign illegal    = conflict | misaligned;
    assign is_load    = MemRead & ~MemWrite;
    assign is_store   = MemWrite & ~MemRead;

    lsu_lane_align u_lane_align (
        .word       (DmReadData),
        .offset     (offset),
        .Size       (Size),
        .SignExt    (SignExt),
        .StoreData  (StoreData),
        .LoadValue  (lane_load),
        .MergedWord (lane_merged)
    );

    // Memory strobes before reset gating; a sub-dword store reads first and
    // writes the merged word from the register in RMW_WRITE.
    always_comb begin
        rd_raw    = 1'b0;
        wr_raw    = 1'b0;
        wdata_raw = '0;
        case (state)
            ST_IDLE: begin
                if (Req && !illegal) begin
                    if (is_load) begin
                        rd_raw = 1'b1;
                    end else if (is_store) begin
                        if (Size == SZ_D) begin
                            wr_raw    = 1'b1;
                            wdata_raw = StoreData;
                        end else begin
                            rd_raw = 1'b1;
                        end
                    end
                end
            end
            ST_RMW_WRITE: begin
                wr_raw    = 1'b1;
                wdata_raw = merged_q;
            end
            default: begin
                rd_raw    = 1'b0;
                wr_raw    = 1'b0;
                wdata_raw = '0;
            end
        endcase
    end

    // Gating with Reset_n keeps memory untouched in any reset cycle,
    // including one that lands on RMW_WRITE.
    assign DmRead      = rd_raw & Reset_n;
    assign DmWrite     = wr_raw & Reset_n;
    assign DmAddress   = (DmRead | DmWrite) ? {Address[ADDR_W-1:3], 3'b000} : '0;
    assign DmWriteData = DmWrite ? wdata_raw : '0;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            load_data_q <= '0;
            merged_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    fault_q <= 1'b0;
                    if (Req && (MemRead || MemWrite)) begin
                        if (illegal) begin
                            fault_q <= 1'b1;
                            state   <= ST_DONE;
                        end else if (is_load) begin
                            load_data_q <= lane_load;
                            state       <= ST_DONE;
                        end else if (Size == SZ_D) begin
                            state <= ST_DONE;
                        end else begin
                            merged_q <= lane_merged;
                            state    <= ST_RMW_WRITE;
                        end
                    end
                end
                ST_RMW_WRITE: state <= ST_DONE;
                ST_DONE:      state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    assign Busy     = (state != ST_IDLE);
    assign Done     = (state == ST_DONE);
    assign Fault    = (state == ST_DONE) & fault_q;
    assign LoadData = load_data_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store sequencer between the CPU datapath and the 64-bit word data memory. It supports byte, halfword, word and doubleword accesses:
- Loads: extracts the addressed lane and zero- or sign-extends it.
- Sub-doubleword stores: performs a read-modify-write sequence on the containing 64-bit word.
- Busy: stalls the datapath while a request is in flight.
- Fault: reports misaligned or conflicting requests without touching memory.

## Interface
Parameters:
- ADDR_W, 64, byte address width
- DATA_W, 64, memory word width (fixed 64; lane logic assumes 8 byte lanes)

Ports:
- Clock  input  1  single clock; all state updates on rising edge
- Reset_n  input  1  reset; synchronous, active-low
- Req  input  1  request strobe; sampled only in IDLE
- MemRead  input  1  request is a load
- MemWrite  input  1  request is a store
- Size  input  2  00 byte, 01 half, 10 word, 11 dword
- SignExt  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- Address  input  64  byte address
- StoreData  input  64  store value, right-justified
- Busy  output  1  high whenever state != IDLE
- Done  output  1  one-cycle pulse, request complete
- Fault  output  1  one-cycle pulse with Done on an illegal request
- LoadData  output  64  extended load result; valid while Done=1, held until the next Done
- DmAddress  output  64  to memory: {Address[63:3],3'b000}
- DmWriteData  output  64  to memory write port
- DmRead  output  1  memory read enable
- DmWrite  output  1  memory write enable; memory writes on the rising edge
- DmReadData  input  64  combinational memory read data

## Operation
- Lanes are little-endian.
  - Offset = Address[2:0].
  - Lane bit position = 8*offset.
  - Lane width is 8/16/32/64 for Size 00/01/10/11.
- Illegal request, which ends IDLE → DONE with Fault=1, no Dm access, and LoadData unchanged:
  - Misaligned: offset is not a multiple of the access size in bytes.
  - Conflicting: MemRead and MemWrite are both high.
- States: IDLE, RMW_WRITE, DONE.
- IDLE, Req with a legal load:
  - DmRead=1 this cycle.
  - Lane extracted from DmReadData, extended per SignExt, registered into LoadData.
  - Next state DONE.
- IDLE, Req with a legal dword store:
  - DmWrite=1 and DmWriteData=StoreData this cycle.
  - Next state DONE.
- IDLE, Req with a legal sub-dword store:
  - DmRead=1 this cycle.
  - Merged word registered: DmReadData with the lane replaced by the low bits of StoreData.
  - Next state RMW_WRITE.
- RMW_WRITE: DmWrite=1, DmWriteData = merged register → DONE.
- DONE: Done=1, Fault as latched → IDLE.
- Req with MemRead=MemWrite=0 is ignored; the FSM stays in IDLE.
- Req is ignored when not in IDLE; the datapath must hold the request while Busy.
- SignExt is ignored for stores and for dword loads.

## Timing
- Reset (Reset_n low at an edge):
  - State → IDLE.
  - LoadData = 0, merged register = 0.
  - Busy, Done, Fault = 0.
- DmWrite and DmRead are gated with Reset_n, so no memory write occurs in a cycle where Reset_n is low. A reset during RMW_WRITE aborts the store and leaves memory unchanged.
- Latency from the Req cycle to the Done pulse:
  - Load: 1 cycle.
  - Dword store: 1 cycle.
  - Sub-dword store: 2 cycles.
  - Fault: 1 cycle.
- Busy:
  - Low in the Req cycle, which is in IDLE.
  - High from the next cycle through the DONE cycle inclusive.
  - Back-to-back requests are possible on the cycle after DONE.
- Dm outputs are combinational from state, Address and the registers. When neither DmRead nor DmWrite is asserted, DmAddress = 0 and DmWriteData = 0.

## Structure
- Shared package `lsu_pkg`:
  - Size encodings: SZ_B, SZ_H, SZ_W, SZ_D.
  - State enum.
  - Function `size_bytes(Size)`.
- One sub-module `lsu_lane_align`, purely combinational:
  - Inputs: word, offset, Size, SignExt, StoreData.
  - Outputs: extended load value and merged store word.
  - Exhaustively testable on its own.
- The top module holds the FSM, the registers and the Dm gating.

## Test plan
Memory model preloaded with:
- 0x08 = 0x000000000000000A
- 0x18 = 0x0FFBEA7DEADBEEFF

Scenarios:
- Load byte 0x18, SignExt=0 then SignExt=1 → LoadData 0x00000000000000FF, then 0xFFFFFFFFFFFFFFFF; Done one cycle after Req.
- Load half 0x1A SignExt=1 → 0xFFFFFFFFFFFFEADB; load word 0x1C SignExt=1 → 0x000000000FFBEA7D.
- Store byte 0xAB to 0x09 → DmRead in the Req cycle, DmWrite the next cycle with 0x000000000000AB0A; Done at +2; Busy high for 2 cycles.
- Store dword 0x1122334455667788 to 0x18 → single write cycle; reload returns the same value.
- Misaligned half load at 0x11, and a Req with MemRead=MemWrite=1 → Fault and Done together at +1; no DmRead/DmWrite; LoadData unchanged.
- Sub-word store to 0x08 with Reset_n low during RMW_WRITE → no DmWrite; 0x08 still holds 0x0A; all outputs 0 next cycle; FSM accepts a new Req afterwards.
